// File: rtl/virtual_input_sequencer_if.sv
// Command channel for the virtual-input sequencer.
// Handshake: the master holds cmd_valid and cmd_data stable until the transfer.
// A transfer happens at any clk edge where cmd_valid & cmd_ready are both high.
interface virtual_input_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;

    modport master (output cmd_valid, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/virtual_input_sequencer.sv
// Turns 8-bit commands into timed number/control strobes for the virtual
// button/switch decoder, and keeps a mirror of the decoder's 22 outputs.
module virtual_input_sequencer #(
    parameter int SETUP_CYCLES = 4,
    parameter int PULSE_CYCLES = 4,
    parameter int PRESS_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    virtual_input_sequencer_if.slave    cmd,
    output logic [4:0]                  number,
    output logic                        control,
    output logic                        busy,
    output logic                        cmd_err,
    output logic [21:0]                 mirror,
    output logic [2:0]                  dbg_state
);

    typedef enum logic [2:0] {
        ST_INIT_SETUP = 3'd0,
        ST_SETUP      = 3'd1,
        ST_HIGH       = 3'd2,
        ST_HOLD       = 3'd3,
        ST_GAP        = 3'd4,
        ST_IDLE       = 3'd5
    } state_t;

    localparam logic [2:0]  OP_TOGGLE  = 3'b000;
    localparam logic [2:0]  OP_PRESS   = 3'b001;
    localparam logic [2:0]  OP_CLEAR   = 3'b010;
    localparam logic [4:0]  CLEAR_IDX  = 5'b11111;
    localparam logic [21:0] CLEAR_MIR  = 22'h00000F;
    localparam logic [15:0] LD_SETUP   = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] LD_PULSE   = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] LD_PRESS   = 16'(PRESS_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [4:0]  r_number;
    logic        r_control;
    logic        r_cmd_err;
    logic [21:0] r_mirror;
    logic        r_is_clear;
    logic        r_press_pending;

    logic [2:0]  w_op;
    logic [4:0]  w_idx;
    logic        w_cmd_ok;
    logic        w_cnt_zero;

    assign w_op       = cmd.cmd_data[7:5];
    assign w_idx      = cmd.cmd_data[4:0];
    assign w_cmd_ok   = (w_op == OP_CLEAR) ||
                        (((w_op == OP_TOGGLE) || (w_op == OP_PRESS)) && (w_idx <= 5'd21));
    assign w_cnt_zero = (r_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_INIT_SETUP;
            r_cnt           <= LD_SETUP;
            r_number        <= CLEAR_IDX;
            r_control       <= 1'b0;
            r_cmd_err       <= 1'b0;
            r_mirror        <= CLEAR_MIR;
            r_is_clear      <= 1'b1;
            r_press_pending <= 1'b0;
        end else begin
            r_cmd_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        if (w_cmd_ok) begin
                            r_number        <= (w_op == OP_CLEAR) ? CLEAR_IDX : w_idx;
                            r_is_clear      <= (w_op == OP_CLEAR);
                            r_press_pending <= (w_op == OP_PRESS);
                            r_cnt           <= LD_SETUP;
                            r_state         <= ST_SETUP;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                end
                ST_INIT_SETUP, ST_SETUP: begin
                    if (w_cnt_zero) begin
                        // Mirror tracks the decoder, which acts on the rising edge.
                        r_mirror  <= r_is_clear ? CLEAR_MIR : (r_mirror ^ (22'd1 << r_number));
                        r_control <= 1'b1;
                        r_cnt     <= LD_PULSE;
                        r_state   <= ST_HIGH;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_HIGH: begin
                    if (w_cnt_zero) begin
                        r_control <= 1'b0;
                        r_cnt     <= LD_SETUP;
                        r_state   <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (w_cnt_zero) begin
                        if (r_press_pending) begin
                            r_press_pending <= 1'b0;
                            r_cnt           <= LD_PRESS;
                            r_state         <= ST_GAP;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_GAP: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= LD_SETUP;
                        r_state <= ST_SETUP;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_INIT_SETUP;
                    r_cnt   <= LD_SETUP;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = (r_state == ST_IDLE) && !reset;
    assign busy          = (r_state != ST_IDLE);
    assign number        = r_number;
    assign control       = r_control;
    assign cmd_err       = r_cmd_err;
    assign mirror        = r_mirror;
    assign dbg_state     = r_state;

endmodule
